// File: rtl/demux_stream_ctrl_pkg.sv
// Shared types and constants for the packet-aware stream demux controller.
// Keeps the FSM encoding and destination codes in one place for all users.
package demux_ctrl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        PACKET = 1'b1
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux_stream_ctrl_if.sv
// Stream bundle between the producer, the demux controller and its two consumers.
// The controller takes the slave view; the environment driving it takes the master view.
interface demux_stream_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inData;
    logic             inSelect;
    logic             inLast;
    logic             outValidA;
    logic             outReadyA;
    logic             outValidB;
    logic             outReadyB;
    logic [WIDTH-1:0] outData;
    logic             outLast;

    modport master (
        output inValid, inData, inSelect, inLast, outReadyA, outReadyB,
        input  inReady, outValidA, outValidB, outData, outLast
    );

    modport slave (
        input  inValid, inData, inSelect, inLast, outReadyA, outReadyB,
        output inReady, outValidA, outValidB, outData, outLast
    );
endinterface

// File: rtl/demux_stream_ctrl_demux.sv
// One-bit demux gate: routes a single input bit to output A or B by select.
// The unselected output is always driven low.
module Demux
    import demux_ctrl_pkg::*;
(
    input  logic in_i,
    input  logic select_i,
    output logic outA_o,
    output logic outB_o
);

    assign outA_o = in_i & (select_i == SEL_A);
    assign outB_o = in_i & (select_i == SEL_B);

endmodule

// File: rtl/demux_stream_ctrl.sv
// Packet-aware valid/ready demux controller with a single registered output stage.
// Locks the destination for a whole packet and forces a packet end at MAX_BEATS.
module demux_stream_ctrl
    import demux_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                clk,
    input  logic                reset,
    demux_stream_ctrl_if.slave  bus,
    output logic                select,
    output logic                busy,
    output logic                overflow
);

    localparam int CW = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_BEATS - 1);

    state_t           state_q, state_d;
    logic             lockedSel_q, lockedSel_d;
    logic [CW-1:0]    beatCount_q, beatCount_d;
    logic             overflow_q, overflow_d;
    logic             regValid_q, regValid_d;
    logic [WIDTH-1:0] regData_q, regData_d;
    logic             regLast_q, regLast_d;
    logic             regSel_q, regSel_d;

    logic drain;
    logic accept;
    logic effSel;
    logic effLast;

    // Ready is combinational from the consumer readies so a full register can pass through at one beat per cycle.
    assign drain   = regValid_q & (regSel_q ? bus.outReadyB : bus.outReadyA);
    assign bus.inReady = ~reset & (~regValid_q | drain);
    assign accept  = bus.inValid & bus.inReady;
    assign effSel  = (state_q == IDLE) ? bus.inSelect : lockedSel_q;
    assign effLast = bus.inLast | (beatCount_q == LAST_COUNT);

    always_comb begin
        regValid_d  = regValid_q;
        regData_d   = regData_q;
        regLast_d   = regLast_q;
        regSel_d    = regSel_q;
        beatCount_d = beatCount_q;
        overflow_d  = overflow_q;
        if (accept) begin
            regValid_d  = 1'b1;
            regData_d   = bus.inData;
            regLast_d   = effLast;
            regSel_d    = effSel;
            beatCount_d = effLast ? '0 : beatCount_q + 1'b1;
            if (effLast && !bus.inLast) begin
                overflow_d = 1'b1;
            end
        end else if (drain) begin
            regValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regValid_q  <= 1'b0;
            regData_q   <= '0;
            regLast_q   <= 1'b0;
            regSel_q    <= SEL_A;
            beatCount_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            regValid_q  <= regValid_d;
            regData_q   <= regData_d;
            regLast_q   <= regLast_d;
            regSel_q    <= regSel_d;
            beatCount_q <= beatCount_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lockedSel_q <= SEL_A;
        end else begin
            state_q     <= state_d;
            lockedSel_q <= lockedSel_d;
        end
    end

    // The destination latched on a packet's first beat holds until the packet closes.
    always_comb begin
        state_d     = state_q;
        lockedSel_d = lockedSel_q;
        case (state_q)
            IDLE: begin
                if (accept && !effLast) begin
                    state_d     = PACKET;
                    lockedSel_d = bus.inSelect;
                end
            end
            PACKET: begin
                if (accept && effLast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == PACKET);
    end

    Demux uDemux (
        .in_i     (regValid_q),
        .select_i (regSel_q),
        .outA_o   (bus.outValidA),
        .outB_o   (bus.outValidB)
    );

    assign bus.outData = regData_q;
    assign bus.outLast = regLast_q;
    assign select      = regSel_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_demux_stream_ctrl.sv
// Testbench for demux_stream_ctrl: directed packet scenarios followed by random traffic,
// all compared against a packet-level reference model every cycle.
module tb_demux_stream_ctrl;

    localparam int WIDTH = 8;
    localparam int MAXB  = 4;

    logic clk = 1'b0;
    logic reset;
    logic select;
    logic busy;
    logic overflow;

    int checks = 0;
    int errors = 0;

    bit              mHeld;
    logic [WIDTH-1:0] mData;
    bit              mLast;
    bit              mSel;
    bit              mOpen;
    bit              mDest;
    bit              mOvf;
    int              mBeats;

    demux_stream_ctrl_if #(.WIDTH(WIDTH)) bus ();

    demux_stream_ctrl #(
        .WIDTH     (WIDTH),
        .MAX_BEATS (MAXB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .select   (select),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit modelReady();
        return !reset && (!mHeld || (mSel ? bus.outReadyB : bus.outReadyA));
    endfunction

    // Packet-level view: beats are counted from 1 within an open packet, destination fixed by its first beat.
    task automatic modelStep();
        bit acc;
        bit drained;
        bit dest;
        bit lastBeat;
        int beats;
        if (reset) begin
            mHeld = 0; mData = '0; mLast = 0; mSel = 0;
            mOpen = 0; mDest = 0; mOvf = 0; mBeats = 0;
        end else begin
            drained = mHeld && (mSel ? bus.outReadyB : bus.outReadyA);
            acc     = bus.inValid && modelReady();
            if (acc) begin
                dest     = mOpen ? mDest : bus.inSelect;
                beats    = mBeats + 1;
                lastBeat = bus.inLast || (beats == MAXB);
                if (beats == MAXB && !bus.inLast) mOvf = 1;
                mHeld = 1; mData = bus.inData; mLast = lastBeat; mSel = dest;
                if (lastBeat) begin
                    mOpen = 0; mBeats = 0;
                end else begin
                    mOpen = 1; mDest = dest; mBeats = beats;
                end
            end else if (drained) begin
                mHeld = 0;
            end
        end
    endtask

    task automatic checkOutput();
        checkValue("outValidA", bus.outValidA, mHeld && !mSel);
        checkValue("outValidB", bus.outValidB, mHeld && mSel);
        checkValue("outData", bus.outData, mData);
        checkValue("outLast", bus.outLast, mLast);
        checkValue("select", select, mSel);
        checkValue("busy", busy, mOpen);
        checkValue("overflow", overflow, mOvf);
    endtask

    task automatic applyStimulus(input bit rst, input bit v, input logic [WIDTH-1:0] d,
                                 input bit s, input bit l, input bit ra, input bit rb);
        reset         = rst;
        bus.inValid   = v;
        bus.inData    = d;
        bus.inSelect  = s;
        bus.inLast    = l;
        bus.outReadyA = ra;
        bus.outReadyB = rb;
        #1;
        checkValue("inReady", bus.inReady, modelReady());
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        $display("[TB] start");
        // Reset with a pending beat: nothing may be accepted.
        applyStimulus(1, 1, 8'h55, 0, 0, 1, 1);
        applyStimulus(1, 1, 8'h55, 0, 0, 1, 1);
        checkValue("tp_reset_busy", busy, 0);
        checkValue("tp_reset_ovf", overflow, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 1, 1);
        checkValue("tp_release_ready", bus.inReady, 1);

        // Single-beat packet to B.
        applyStimulus(0, 1, 8'hA5, 1, 1, 1, 1);
        checkValue("tp_b_valid", bus.outValidB, 1);
        checkValue("tp_b_data", bus.outData, 8'hA5);
        checkValue("tp_b_busy", busy, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 1, 1);

        // Destination lock: later inSelect changes are ignored mid-packet.
        applyStimulus(0, 1, 8'h01, 0, 0, 1, 1);
        checkValue("tp_lock_busy1", busy, 1);
        applyStimulus(0, 1, 8'h02, 1, 0, 1, 1);
        checkValue("tp_lock_validA2", bus.outValidA, 1);
        applyStimulus(0, 1, 8'h03, 1, 1, 1, 1);
        checkValue("tp_lock_validA3", bus.outValidA, 1);
        checkValue("tp_lock_last3", bus.outLast, 1);
        checkValue("tp_lock_busy3", busy, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 1, 1);

        // Backpressure on A, then drain and accept in the same cycle.
        applyStimulus(0, 1, 8'h11, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 8'h12, 0, 1, 0, 1);
            checkValue("tp_bp_hold", bus.outData, 8'h11);
        end
        applyStimulus(0, 1, 8'h12, 0, 1, 1, 0);
        checkValue("tp_bp_next", bus.outData, 8'h12);
        applyStimulus(0, 0, 8'h00, 0, 0, 1, 1);

        // Overflow: fourth beat forced last, fifth opens a new packet to A.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 8'(8'h20 + i), 1, 0, 1, 1);
        end
        checkValue("tp_ovf_data", bus.outData, 8'h23);
        checkValue("tp_ovf_last", bus.outLast, 1);
        checkValue("tp_ovf_flag", overflow, 1);
        applyStimulus(0, 1, 8'h24, 0, 0, 1, 1);
        checkValue("tp_ovf_nextA", bus.outValidA, 1);
        checkValue("tp_ovf_busy", busy, 1);
        applyStimulus(0, 1, 8'h25, 1, 1, 1, 1);

        // Reset in the middle of a B packet.
        applyStimulus(0, 1, 8'h30, 1, 0, 1, 1);
        applyStimulus(0, 1, 8'h31, 1, 0, 1, 0);
        applyStimulus(1, 0, 8'h00, 0, 0, 1, 0);
        checkValue("tp_mid_validB", bus.outValidB, 0);
        checkValue("tp_mid_busy", busy, 0);
        applyStimulus(0, 1, 8'h40, 0, 1, 1, 1);
        checkValue("tp_mid_newA", bus.outValidA, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 79) == 0,
                          $urandom_range(0, 3) != 0,
                          8'($urandom),
                          1'($urandom),
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
